requant_activation_unit: RTL and testbench

- Consumer at the read end of the systolic array output buffer.
- Pops one unquantized int32 accumulator per handshake, together with its row/col, and drives the buffer's consume strobe.
- Requantizes each value to int8 with a fixed-point multiplier, a rounding right shift, a zero-point offset and an optional ReLU.
- Emits a flat-address int8 write to the activation memory through a 3-stage stallable pipeline.

---
 rtl/requant_activation_unit_if.sv | 25 ++
 rtl/requant_activation_unit.sv | 117 +++++++++++
 tb/tb_requant_activation_unit.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/requant_activation_unit_if.sv
// Pop/write handshake bundle between the output buffer, the requant unit and
// the activation memory.
interface requant_activation_unit_if #(
  parameter int N_BITS = 9
);
  logic                      in_valid;
  logic signed [31:0]        in_output;
  logic [N_BITS-1:0]         in_row;
  logic [N_BITS-1:0]         in_col;
  logic                      in_consume;
  logic                      wr_en;
  logic [2*N_BITS-1:0]       wr_addr;
  logic signed [7:0]         wr_data;
  logic                      wr_ready;

  modport master (
    output in_valid, in_output, in_row, in_col, wr_ready,
    input  in_consume, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_output, in_row, in_col, wr_ready,
    output in_consume, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/requant_activation_unit.sv
// Requantizes int32 accumulators to int8 (Q31 multiply, rounding shift, zero
// point, optional ReLU, clamp) through a 3-stage globally-stalled pipeline.
module requant_activation_unit #(
  parameter int MAX_N     = 512,
  parameter int N_BITS    = $clog2(MAX_N),
  parameter int ADDR_BITS = 2*N_BITS
) (
  input  logic                     clk,
  input  logic                     reset_n,
  requant_activation_unit_if.slave io,
  input  logic signed [31:0]       cfg_qmult,
  input  logic [4:0]               cfg_qshift,
  input  logic signed [7:0]        cfg_zero_point,
  input  logic                     cfg_relu_en,
  input  logic [N_BITS-1:0]        cfg_num_cols,
  output logic                     idle
);

  localparam int DATA_W = 32;
  localparam int COEF_W = 32;
  localparam logic signed [DATA_W-1:0] INT32_MIN = 32'sh8000_0000;
  localparam logic signed [DATA_W-1:0] INT32_MAX = 32'sh7fff_ffff;

  // Rounding doubling high multiply; the only overflow is MIN*MIN.
  function automatic logic signed [DATA_W-1:0] rdhm(
    input logic signed [DATA_W+COEF_W-1:0] p,
    input logic                            sat
  );
    if (sat) return INT32_MAX;
    return 32'((p + 64'sd1073741824) >>> 31);
  endfunction

  function automatic logic signed [DATA_W-1:0] round_shift(
    input logic signed [DATA_W-1:0] hi,
    input logic [4:0]               s
  );
    logic [DATA_W-1:0] mask, rem, thr;
    mask = (32'd1 << s) - 32'd1;
    rem  = hi & mask;
    thr  = (mask >> 1) + {31'd0, hi[DATA_W-1]};
    return (hi >>> s) + ((rem > thr) ? 32'sd1 : 32'sd0);
  endfunction

  // 33-bit sum so the zero-point offset can never wrap before clamping.
  function automatic logic signed [7:0] offset_relu_clamp(
    input logic signed [DATA_W-1:0] res,
    input logic signed [7:0]        zp,
    input logic                     relu
  );
    logic signed [DATA_W:0] v, z;
    z = 33'(zp);
    v = 33'(res) + z;
    if (relu && (v < z)) v = z;
    if (v > 33'sd127) return 8'sd127;
    if (v < -33'sd128) return -8'sd128;
    return 8'(v);
  endfunction

  logic                              advance;
  logic                              vld_p0_q, vld_p1_q, vld_p2_q;
  logic signed [DATA_W+COEF_W-1:0]   prod_d, prod_p0_q;
  logic                              sat_d, sat_p0_q;
  logic [ADDR_BITS-1:0]              addr_d, addr_p0_q, addr_p1_q, wr_addr_q;
  logic signed [DATA_W-1:0]          res_d, res_p1_q;
  logic signed [7:0]                 act_d, wr_data_q;

  assign advance       = !vld_p2_q || io.wr_ready;
  assign io.in_consume = reset_n && io.in_valid && advance;

  always_comb begin
    prod_d = 64'(io.in_output) * 64'(cfg_qmult);
    sat_d  = (io.in_output == INT32_MIN) && (cfg_qmult == INT32_MIN);
    addr_d = ADDR_BITS'(io.in_row) * ADDR_BITS'(cfg_num_cols) + ADDR_BITS'(io.in_col);
    res_d  = round_shift(rdhm(prod_p0_q, sat_p0_q), cfg_qshift);
    act_d  = offset_relu_clamp(res_p1_q, cfg_zero_point, cfg_relu_en);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      vld_p0_q <= 1'b0;
      vld_p1_q <= 1'b0;
      vld_p2_q <= 1'b0;
    end else if (advance) begin
      vld_p0_q <= io.in_consume;
      vld_p1_q <= vld_p0_q;
      vld_p2_q <= vld_p1_q;
    end
  end

  // S1: product, saturation flag, flat address | S2: high multiply + shift
  always_ff @(posedge clk) begin
    if (advance) begin
      prod_p0_q <= prod_d;
      sat_p0_q  <= sat_d;
      addr_p0_q <= addr_d;
      res_p1_q  <= res_d;
      addr_p1_q <= addr_p0_q;
    end
  end

  // S3: offset, ReLU, clamp; registers feed the write port directly
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else if (advance) begin
      wr_addr_q <= addr_p1_q;
      wr_data_q <= act_d;
    end
  end

  assign io.wr_en   = vld_p2_q;
  assign io.wr_addr = wr_addr_q;
  assign io.wr_data = wr_data_q;
  assign idle       = !vld_p0_q && !vld_p1_q && !vld_p2_q && !io.in_valid;

endmodule

// File: tb/tb_requant_activation_unit.sv
// Directed-vector bench for requant_activation_unit with hand-computed results.
module tb_requant_activation_unit;

  localparam int N_BITS = 9;
  localparam int Q30    = 32'sh4000_0000;
  localparam int IMIN   = 32'sh8000_0000;

  logic                     clk = 1'b0;
  logic                     reset_n;
  logic signed [31:0]       cfg_qmult;
  logic [4:0]               cfg_qshift;
  logic signed [7:0]        cfg_zero_point;
  logic                     cfg_relu_en;
  logic [N_BITS-1:0]        cfg_num_cols;
  logic                     idle;
  int                       checks = 0;
  int                       errors = 0;

  requant_activation_unit_if #(.N_BITS(N_BITS)) bus ();

  requant_activation_unit #(.MAX_N(512)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .io             (bus.slave),
    .cfg_qmult      (cfg_qmult),
    .cfg_qshift     (cfg_qshift),
    .cfg_zero_point (cfg_zero_point),
    .cfg_relu_en    (cfg_relu_en),
    .cfg_num_cols   (cfg_num_cols),
    .idle           (idle)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  task automatic set_cfg(input int ncols, input int qmult, input int qshift,
                         input int zp, input bit relu);
    cfg_num_cols   = N_BITS'(ncols);
    cfg_qmult      = qmult;
    cfg_qshift     = 5'(qshift);
    cfg_zero_point = 8'(zp);
    cfg_relu_en    = relu;
  endtask

  // One isolated pop; checks the pop strobe, the 3-cycle latency and the write.
  task automatic run_one(input string tag, input int out, input int row, input int col,
                         input int ncols, input int qmult, input int qshift, input int zp,
                         input bit relu, input int exp_addr, input int exp_data);
    @(posedge clk); #1;
    chk({tag, "_idle"}, idle, 1);
    set_cfg(ncols, qmult, qshift, zp, relu);
    bus.wr_ready  = 1'b1;
    bus.in_valid  = 1'b1;
    bus.in_output = out;
    bus.in_row    = N_BITS'(row);
    bus.in_col    = N_BITS'(col);
    @(negedge clk);
    chk({tag, "_pop"}, bus.in_consume, 1);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_lat1"}, bus.wr_en, 0);
    @(negedge clk);
    chk({tag, "_lat2"}, bus.wr_en, 0);
    @(negedge clk);
    chk({tag, "_wr_en"}, bus.wr_en, 1);
    chk({tag, "_addr"}, bus.wr_addr, exp_addr);
    chk({tag, "_data"}, bus.wr_data, exp_data);
  endtask

  initial begin
    int  popped, wcnt, early;
    bit  cons;

    reset_n       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.wr_ready  = 1'b1;
    bus.in_output = '0;
    bus.in_row    = '0;
    bus.in_col    = '0;
    set_cfg(16, Q30, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    chk("rst_wr_en", bus.wr_en, 0);
    chk("rst_addr", bus.wr_addr, 0);
    chk("rst_data", bus.wr_data, 0);
    chk("rst_consume", bus.in_consume, 0);
    chk("rst_idle", idle, 1);
    bus.in_valid = 1'b1;
    #1;
    chk("rst_idle_inv", idle, 0);
    chk("rst_consume_inv", bus.in_consume, 0);
    bus.in_valid = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    run_one("basic",    100,       2,   3,   16,  Q30,  0,  0,   0, 35,     50);
    run_one("zp",       -100,      1,   5,   16,  Q30,  0,  -10, 0, 21,     -60);
    run_one("relu",     -100,      4,   15,  16,  Q30,  0,  -10, 1, 79,     -10);
    run_one("relu_pos", 100,       0,   1,   16,  Q30,  0,  -10, 1, 1,      40);
    run_one("rs_p200",  200,       3,   0,   16,  Q30,  3,  0,   0, 48,     13);
    run_one("rs_m200",  -200,      3,   1,   16,  Q30,  3,  0,   0, 49,     -13);
    run_one("rs_m198",  -198,      3,   2,   16,  Q30,  3,  0,   0, 50,     -12);
    run_one("rs_half",  -6,        0,   0,   16,  Q30,  1,  0,   0, 0,      -2);
    run_one("zp_pos",   200,       8,   0,   16,  Q30,  3,  100, 0, 128,    113);
    run_one("q075",     3,         2,   2,   16,  32'sd1610612736, 0, 0, 0, 34, 2);
    run_one("sat",      IMIN,      5,   5,   16,  IMIN, 0,  0,   0, 85,     127);
    run_one("sat_s31",  IMIN,      0,   7,   16,  IMIN, 31, 0,   0, 7,      1);
    run_one("clamp_hi", 1 << 20,   6,   6,   16,  Q30,  0,  0,   0, 102,    127);
    run_one("clamp_lo", -(1 << 20), 7,  7,   16,  Q30,  0,  0,   0, 119,    -128);
    run_one("addr_max", 0,         511, 511, 511, Q30,  0,  5,   0, 261632, 5);

    // Backpressure: 5 entries offered, memory not ready until cycle 9
    set_cfg(16, Q30, 0, 0, 1'b0);
    popped = 0;
    wcnt   = 0;
    early  = 0;
    for (int c = 0; c < 24; c++) begin
      @(posedge clk); #1;
      bus.wr_ready = (c >= 9);
      if (popped < 5) begin
        bus.in_valid  = 1'b1;
        bus.in_output = 20 * (popped + 1);
        bus.in_row    = N_BITS'(1);
        bus.in_col    = N_BITS'(popped);
      end else begin
        bus.in_valid = 1'b0;
      end
      @(negedge clk);
      cons = bus.in_consume;
      if (c >= 3 && c <= 8) begin
        chk("bp_hold_en", bus.wr_en, 1);
        chk("bp_hold_addr", bus.wr_addr, 16);
        chk("bp_hold_data", bus.wr_data, 10);
        chk("bp_stall_pop", bus.in_consume, 0);
      end
      if (bus.wr_en && bus.wr_ready) begin
        if (wcnt < 5) begin
          chk("bp_addr", bus.wr_addr, 16 + wcnt);
          chk("bp_data", bus.wr_data, 10 * (wcnt + 1));
        end
        wcnt++;
      end
      if (cons) begin
        popped++;
        if (c <= 8) early++;
      end
    end
    chk("bp_early_pops", early, 3);
    chk("bp_pops", popped, 5);
    chk("bp_writes", wcnt, 5);
    chk("bp_idle", idle, 1);

    // Async reset with all three stages holding entries
    bus.wr_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      bus.in_valid  = 1'b1;
      bus.in_output = 40;
      bus.in_row    = N_BITS'(2);
      bus.in_col    = N_BITS'(c);
      @(negedge clk);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk("ar_full_en", bus.wr_en, 1);
    chk("ar_full_idle", idle, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk("ar_async_en", bus.wr_en, 0);
    chk("ar_async_addr", bus.wr_addr, 0);
    chk("ar_async_data", bus.wr_data, 0);
    chk("ar_async_idle", idle, 1);
    @(posedge clk);
    @(negedge clk);
    reset_n      = 1'b1;
    bus.wr_ready = 1'b1;
    @(negedge clk);
    chk("ar_post_idle", idle, 1);
    chk("ar_post_en", bus.wr_en, 0);
    run_one("ar_basic", 100, 2, 3, 16, Q30, 0, 0, 0, 35, 50);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
